// File: rtl/fib_lfsr_stepper.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fib_lfsr_stepper
//
// Purpose:
//   Fibonacci LFSR engine paced by the slow divided clock from clock_div.
//   Everything runs in the fast clk domain. tick_clk is treated as data: it is
//   synchronised, rising-edge detected, and each detected edge (in RUN) or
//   each step pulse (in IDLE) advances the LFSR by one shift. A step counter
//   and a period-length capture support display and verification.
//
// Configuration:
//   LFSR_LOCKUP_GUARD_EN  When defined, the all-zero lock-up state can never be
//                         entered: a zero seed on load and any advance that
//                         would produce zero both substitute SEED_DEFAULT.
//                         When undefined, a zero seed is loaded verbatim and
//                         the register then stays at zero.
//
// Parameters:
//   WIDTH         LFSR length in bits (>= 3)
//   TAPS          feedback mask; bit i set => state[i] enters the XOR
//   SEED_DEFAULT  reset / fallback seed (nonzero)
//   COUNT_W       width of step_count and period_len
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous reset, active-low
//   tick_clk     in   divided clock; only its rising edges are used
//   seed         in   seed captured on load
//   load         in   1-cycle pulse: load seed, clear step counter
//   run          in   level: 1 = advance on every tick
//   step         in   1-cycle pulse: single advance while IDLE
//   q            out  LFSR state
//   bit_out      out  MSB of q
//   step_valid   out  1-cycle pulse in the cycle after q advanced
//   step_count   out  advances since last load/reset (wraps silently)
//   period_wrap  out  1-cycle pulse when the new q equals the loaded seed
//   period_len   out  step_count (post-increment) captured at period_wrap
// -----------------------------------------------------------------------------
module fib_lfsr_stepper #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = 8'h01,
    parameter int               COUNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_clk,
    input  logic [WIDTH-1:0]   seed,
    input  logic               load,
    input  logic               run,
    input  logic               step,
    output logic [WIDTH-1:0]   q,
    output logic               bit_out,
    output logic               step_valid,
    output logic [COUNT_W-1:0] step_count,
    output logic               period_wrap,
    output logic [COUNT_W-1:0] period_len
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // -------------------------------------------------------------------------
    // tick_clk synchroniser and rising-edge detector
    // -------------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic tick_pulse;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its neighbours; with = the chain would collapse
    // into a single stage and the edge detector would never fire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= tick_clk;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // High for exactly one clk after the synchronised level rises, so the
    // LFSR moves on the third clk edge after tick_clk goes high.
    assign tick_pulse = sync2_q & ~prev_q;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    state_e             state_q,  state_d;
    logic [WIDTH-1:0]   lfsr_q,   lfsr_d;
    logic [WIDTH-1:0]   seed_q,   seed_d;
    logic [COUNT_W-1:0] count_q,  count_d;
    logic [COUNT_W-1:0] plen_q,   plen_d;
    logic               valid_q,  valid_d;
    logic               wrap_q,   wrap_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED_DEFAULT;
            seed_q  <= SEED_DEFAULT;
            count_q <= '0;
            plen_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            seed_q  <= seed_d;
            count_q <= count_d;
            plen_q  <= plen_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    // -------------------------------------------------------------------------
    // Feedback and candidate values
    // -------------------------------------------------------------------------
    logic             fb;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] adv_value;
    logic [WIDTH-1:0] load_value;

    // Reduction XOR over the tapped bits.
    assign fb      = ^(lfsr_q & TAPS);
    assign shifted = {lfsr_q[WIDTH-2:0], fb};

`ifdef LFSR_LOCKUP_GUARD_EN
    // Zero is the only state a Fibonacci LFSR can never leave; steer around
    // it on both entry paths.
    assign adv_value  = (shifted == '0) ? SEED_DEFAULT : shifted;
    assign load_value = (seed == '0)    ? SEED_DEFAULT : seed;
`else
    assign adv_value  = shifted;
    assign load_value = seed;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic: load > advance > hold
    // -------------------------------------------------------------------------
    logic advance;

    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would make synthesis infer a latch to hold it.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        seed_d  = seed_q;
        count_d = count_q;
        plen_d  = plen_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        advance = 1'b0;

        if (load) begin
            // Load wins over any step or tick in the same cycle and produces
            // no step_valid / period_wrap; period_len keeps its last capture.
            lfsr_d  = load_value;
            seed_d  = load_value;
            count_d = '0;
            state_d = run ? ST_RUN : ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // Ticks are ignored here, so a coincident step and tick
                    // can only ever yield a single advance.
                    advance = step;
                    if (run) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A tick arriving in the same cycle that run drops is
                    // still honoured; only later ticks are ignored.
                    advance = tick_pulse;
                    if (!run) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (advance) begin
                lfsr_d  = adv_value;
                count_d = count_q + COUNT_W'(1);
                valid_d = 1'b1;
                // Compare against the value being written, so the flag lines
                // up with step_valid in the cycle q shows the new state.
                if (adv_value == seed_q) begin
                    wrap_d = 1'b1;
                    plen_d = count_d;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign q           = lfsr_q;
    assign bit_out     = lfsr_q[WIDTH-1];
    assign step_valid  = valid_q;
    assign step_count  = count_q;
    assign period_wrap = wrap_q;
    assign period_len  = plen_q;

endmodule

// File: tb/tb_fib_lfsr_stepper.sv
`timescale 1ns/1ps
module tb_fib_lfsr_stepper;

    logic        clk;
    logic        rst;
    logic        tick_clk;
    logic [7:0]  seed;
    logic        load;
    logic        run;
    logic        step;
    logic [7:0]  q;
    logic        bit_out;
    logic        step_valid;
    logic [15:0] step_count;
    logic        period_wrap;
    logic [15:0] period_len;

    int n_pass  = 0;
    int n_total = 0;

    fib_lfsr_stepper dut (
        .clk         (clk),
        .rst         (rst),
        .tick_clk    (tick_clk),
        .seed        (seed),
        .load        (load),
        .run         (run),
        .step        (step),
        .q           (q),
        .bit_out     (bit_out),
        .step_valid  (step_valid),
        .step_count  (step_count),
        .period_wrap (period_wrap),
        .period_len  (period_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, required completion before 5000000 ns");
        $fatal(1, "watchdog expired");
    end

    // All tasks start and end right after a falling clk edge.
    task automatic do_load(input logic [7:0] s);
        seed = s;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_step();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    // One tick_clk period (5 clk high, 5 clk low). Reports whether q held for
    // the first two edges, q and step_valid after the third edge, and the
    // number of period_wrap pulses seen. Optionally drops run in the cycle
    // where the synchronised edge is being detected.
    task automatic send_tick(input logic drop_run, output logic early_ok,
                             output logic [7:0] q_new, output logic sv_new,
                             output int wraps);
        logic [7:0] q_before;
        q_before = q;
        wraps    = 0;
        early_ok = 1'b1;
        tick_clk = 1'b1;
        for (int e = 0; e < 2; e++) begin
            @(negedge clk);
            wraps += int'(period_wrap);
            if (q !== q_before) early_ok = 1'b0;
        end
        if (drop_run) run = 1'b0;
        @(negedge clk);
        wraps += int'(period_wrap);
        q_new  = q;
        sv_new = step_valid;
        repeat (2) begin
            @(negedge clk);
            wraps += int'(period_wrap);
        end
        tick_clk = 1'b0;
        repeat (5) begin
            @(negedge clk);
            wraps += int'(period_wrap);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick_clk = 1'b0; seed = 8'h00; load = 1'b0; run = 1'b0; step = 1'b0;
        #1 rst = 1'b0;
        #1;
        n_total++; if (q !== 8'h01) $display("FAIL reset_async_q: got %h required %h", q, 8'h01); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (q !== 8'h01) $display("FAIL reset_q: got %h required %h", q, 8'h01); else n_pass++;
        n_total++; if (step_count !== 16'd0) $display("FAIL reset_count: got %0d required 0", step_count); else n_pass++;
        n_total++; if (step_valid !== 1'b0) $display("FAIL reset_step_valid: got %b required 0", step_valid); else n_pass++;
        n_total++; if (period_wrap !== 1'b0) $display("FAIL reset_period_wrap: got %b required 0", period_wrap); else n_pass++;
        n_total++; if (bit_out !== 1'b0) $display("FAIL reset_bit_out: got %b required 0", bit_out); else n_pass++;
        n_total++; if (period_len !== 16'd0) $display("FAIL reset_period_len: got %0d required 0", period_len); else n_pass++;
    endtask

    task automatic test_idle_step();
        logic [7:0] exp_q [4];
        exp_q = '{8'h02, 8'h04, 8'h08, 8'h11};
        do_load(8'h01);
        n_total++; if (q !== 8'h01) $display("FAIL idle_load_q: got %h required 01", q); else n_pass++;
        n_total++; if (step_valid !== 1'b0) $display("FAIL idle_load_sv: got %b required 0", step_valid); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            do_step();
            n_total++; if (q !== exp_q[i]) $display("FAIL idle_step_q[%0d]: got %h required %h", i, q, exp_q[i]); else n_pass++;
            n_total++; if (step_valid !== 1'b1) $display("FAIL idle_step_sv[%0d]: got %b required 1", i, step_valid); else n_pass++;
            @(negedge clk);
            n_total++; if (step_valid !== 1'b0) $display("FAIL idle_step_sv_drop[%0d]: got %b required 0", i, step_valid); else n_pass++;
        end
        n_total++; if (step_count !== 16'd4) $display("FAIL idle_step_count: got %0d required 4", step_count); else n_pass++;
    endtask

    task automatic test_run_period();
        logic       early_ok, sv_new;
        logic [7:0] q_new, q_prev;
        int         w, wrap_total, lat_err;
        wrap_total = 0;
        lat_err    = 0;
        do_load(8'h01);
        run = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 255; i++) begin
            q_prev = q;
            send_tick(1'b0, early_ok, q_new, sv_new, w);
            wrap_total += w;
            if (!early_ok || sv_new !== 1'b1 || q_new === q_prev) lat_err++;
            if (i == 3) begin
                n_total++; if (q_new !== 8'h11) $display("FAIL run_q_tick4: got %h required 11", q_new); else n_pass++;
            end
        end
        n_total++; if (lat_err !== 0) $display("FAIL run_tick_latency: got %0d bad ticks required 0", lat_err); else n_pass++;
        n_total++; if (q !== 8'h01) $display("FAIL run_period_q: got %h required 01", q); else n_pass++;
        n_total++; if (wrap_total !== 1) $display("FAIL run_wrap_count: got %0d required 1", wrap_total); else n_pass++;
        n_total++; if (period_len !== 16'd255) $display("FAIL run_period_len: got %0d required 255", period_len); else n_pass++;
        n_total++; if (step_count !== 16'd255) $display("FAIL run_step_count: got %0d required 255", step_count); else n_pass++;
    endtask

    task automatic test_run_ignores_step();
        logic       early_ok, sv_new;
        logic [7:0] q_new;
        int         w;
        send_tick(1'b0, early_ok, q_new, sv_new, w);
        n_total++; if (q_new !== 8'h02) $display("FAIL run_step_tick1: got %h required 02", q_new); else n_pass++;
        do_step();
        n_total++; if (q !== 8'h02) $display("FAIL run_step_ignored_q: got %h required 02", q); else n_pass++;
        n_total++; if (step_valid !== 1'b0) $display("FAIL run_step_ignored_sv: got %b required 0", step_valid); else n_pass++;
        send_tick(1'b0, early_ok, q_new, sv_new, w);
        n_total++; if (q_new !== 8'h04) $display("FAIL run_step_tick2: got %h required 04", q_new); else n_pass++;
        // Tick coinciding with run dropping is still taken.
        send_tick(1'b1, early_ok, q_new, sv_new, w);
        n_total++; if (q_new !== 8'h08) $display("FAIL run_drop_tick: got %h required 08", q_new); else n_pass++;
        send_tick(1'b0, early_ok, q_new, sv_new, w);
        n_total++; if (q_new !== 8'h08) $display("FAIL idle_tick_ignored_q: got %h required 08", q_new); else n_pass++;
        n_total++; if (step_count !== 16'd258) $display("FAIL run_drop_count: got %0d required 258", step_count); else n_pass++;
    endtask

    task automatic test_load_during_tick();
        logic       early_ok, sv_new;
        logic [7:0] q_new;
        int         w;
        run = 1'b1;
        @(negedge clk);
        tick_clk = 1'b1;
        repeat (2) @(negedge clk);
        // tick_pulse is high in this cycle; load must win.
        do_load(8'hA5);
        n_total++; if (q !== 8'hA5) $display("FAIL load_tick_q: got %h required a5", q); else n_pass++;
        n_total++; if (step_count !== 16'd0) $display("FAIL load_tick_count: got %0d required 0", step_count); else n_pass++;
        n_total++; if (step_valid !== 1'b0) $display("FAIL load_tick_sv: got %b required 0", step_valid); else n_pass++;
        n_total++; if (period_len !== 16'd255) $display("FAIL load_keeps_plen: got %0d required 255", period_len); else n_pass++;
        repeat (2) @(negedge clk);
        tick_clk = 1'b0;
        repeat (5) @(negedge clk);
        n_total++; if (q !== 8'hA5) $display("FAIL load_tick_hold: got %h required a5", q); else n_pass++;
        // A5: taps 7,5,4,3 = 1,1,0,0 -> fb 0 -> 4A.
        send_tick(1'b0, early_ok, q_new, sv_new, w);
        n_total++; if (q_new !== 8'h4A) $display("FAIL load_next_tick_q: got %h required 4a", q_new); else n_pass++;
        n_total++; if (sv_new !== 1'b1) $display("FAIL load_next_tick_sv: got %b required 1", sv_new); else n_pass++;
        run = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_step_tick_coincide();
        tick_clk = 1'b1;
        repeat (2) @(negedge clk);
        do_step();
        // 4A: taps = 0,0,0,1 -> fb 1 -> 95.
        n_total++; if (q !== 8'h95) $display("FAIL coincide_q: got %h required 95", q); else n_pass++;
        @(negedge clk);
        n_total++; if (q !== 8'h95) $display("FAIL coincide_single: got %h required 95", q); else n_pass++;
        n_total++; if (step_count !== 16'd2) $display("FAIL coincide_count: got %0d required 2", step_count); else n_pass++;
        tick_clk = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_count_wrap();
        do_load(8'h01);
        step = 1'b1;
        repeat (65535) @(negedge clk);
        step = 1'b0;
        // 65535 = 257 * 255 advances: back at the seed.
        n_total++; if (step_count !== 16'hFFFF) $display("FAIL wrap_count_max: got %h required ffff", step_count); else n_pass++;
        n_total++; if (q !== 8'h01) $display("FAIL wrap_q_max: got %h required 01", q); else n_pass++;
        n_total++; if (period_wrap !== 1'b1) $display("FAIL wrap_pw_max: got %b required 1", period_wrap); else n_pass++;
        n_total++; if (period_len !== 16'hFFFF) $display("FAIL wrap_plen_max: got %h required ffff", period_len); else n_pass++;
        do_step();
        n_total++; if (step_count !== 16'h0000) $display("FAIL wrap_count_zero: got %h required 0000", step_count); else n_pass++;
        n_total++; if (q !== 8'h02) $display("FAIL wrap_q_after: got %h required 02", q); else n_pass++;
        n_total++; if (period_wrap !== 1'b0) $display("FAIL wrap_pw_after: got %b required 0", period_wrap); else n_pass++;
    endtask

    task automatic test_lockup();
        do_load(8'h00);
`ifdef LFSR_LOCKUP_GUARD_EN
        n_total++; if (q !== 8'h01) $display("FAIL lockup_guard_load: got %h required 01", q); else n_pass++;
        do_step();
        n_total++; if (q !== 8'h02) $display("FAIL lockup_guard_step: got %h required 02", q); else n_pass++;
        n_total++; if (period_wrap !== 1'b0) $display("FAIL lockup_guard_pw: got %b required 0", period_wrap); else n_pass++;
`else
        n_total++; if (q !== 8'h00) $display("FAIL lockup_load: got %h required 00", q); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            do_step();
            n_total++; if (q !== 8'h00) $display("FAIL lockup_q[%0d]: got %h required 00", i, q); else n_pass++;
            n_total++; if (period_wrap !== 1'b1) $display("FAIL lockup_pw[%0d]: got %b required 1", i, period_wrap); else n_pass++;
        end
        n_total++; if (step_count !== 16'd5) $display("FAIL lockup_count: got %0d required 5", step_count); else n_pass++;
        n_total++; if (period_len !== 16'd5) $display("FAIL lockup_plen: got %0d required 5", period_len); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid_run();
        logic       early_ok, sv_new;
        logic [7:0] q_new;
        int         w;
        do_load(8'h01);
        run = 1'b1;
        @(negedge clk);
        send_tick(1'b0, early_ok, q_new, sv_new, w);
        n_total++; if (q_new !== 8'h02) $display("FAIL midrun_pre_q: got %h required 02", q_new); else n_pass++;
        tick_clk = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++; if (q !== 8'h01) $display("FAIL midrun_rst_q: got %h required 01", q); else n_pass++;
        n_total++; if (step_count !== 16'd0) $display("FAIL midrun_rst_count: got %0d required 0", step_count); else n_pass++;
        n_total++; if (period_len !== 16'd0) $display("FAIL midrun_rst_plen: got %0d required 0", period_len); else n_pass++;
        tick_clk = 1'b0;
        run = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        n_total++; if (q !== 8'h01) $display("FAIL midrun_discard_q: got %h required 01", q); else n_pass++;
        n_total++; if (step_valid !== 1'b0) $display("FAIL midrun_discard_sv: got %b required 0", step_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_idle_step();
        test_run_period();
        test_run_ignores_step();
        test_load_during_tick();
        test_step_tick_coincide();
        test_count_wrap();
        test_lockup();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
